// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on magnitudes.
// Latency: start sampled at edge N, done in cycle N+34 (N+1 for divide-by-zero/overflow); busy stalls the pipe.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      counter_q, counter_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [WIDTH-1:0]   a_abs_q, a_abs_d;
   logic [WIDTH-1:0]   b_abs_q, b_abs_d;
   logic               a_neg_q, a_neg_d;
   logic               b_neg_q, b_neg_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   fix_q, fix_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               in_div, a_signed, b_signed, a_sign, b_sign;
   logic               div_zero, div_ovf;
   logic [WIDTH-1:0]   a_abs_in, b_abs_in, special_res;
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_sub, quot_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;

   // Operand decode for the request currently presented in IDLE
   assign in_div   = funct3[2];
   assign a_signed = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
   assign b_signed = in_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
   assign a_sign   = a_signed & operand_a[WIDTH-1];
   assign b_sign   = b_signed & operand_b[WIDTH-1];
   assign a_abs_in = a_sign ? -operand_a : operand_a;
   assign b_abs_in = b_sign ? -operand_b : operand_b;
   assign div_zero = in_div && (operand_b == '0);
   assign div_ovf  = in_div && !funct3[0] && (operand_a == MIN_NEG) && (operand_b == '1);
   assign special_res = div_zero ? (funct3[1] ? operand_a : '1)
                                 : (funct3[1] ? '0 : MIN_NEG);

   // Iteration datapath: acc holds {hi, multiplier} for multiply, {rem, quot} for divide
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_abs_q} : '0);
   assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign rem_ge   = rem_sh >= {1'b0, b_abs_q};
   assign rem_sub  = rem_sh[WIDTH-1:0] - b_abs_q;

   assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
   assign quot_fix = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      funct3_d  = funct3_q;
      a_abs_d   = a_abs_q;
      b_abs_d   = b_abs_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      acc_d     = acc_q;
      fix_d     = fix_q;
      result_d  = result_q;

      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               funct3_d  = funct3;
               a_abs_d   = a_abs_in;
               b_abs_d   = b_abs_in;
               a_neg_d   = a_sign;
               b_neg_d   = b_sign;
               counter_d = '0;
               if (div_zero || div_ovf) begin
                  fix_d   = special_res;
                  state_d = DONE;
               end else begin
                  acc_d   = in_div ? {{WIDTH{1'b0}}, a_abs_in} : {{WIDTH{1'b0}}, b_abs_in};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (funct3_q[2])
               acc_d = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
            else
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            counter_d = counter_q + CW'(1);
            if (counter_q == CW'(WIDTH-1))
               state_d = FIX;
         end
         FIX: begin
            if (funct3_q[2])
               fix_d = funct3_q[1] ? rem_fix : quot_fix;
            else if (funct3_q[1:0] == 2'b00)
               fix_d = prod_fix[WIDTH-1:0];
            else
               fix_d = prod_fix[2*WIDTH-1:WIDTH];
            state_d = DONE;
         end
         DONE: begin
            result_d = fix_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort drops the op without publishing anything
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         counter_q <= '0;
         funct3_q  <= '0;
         a_abs_q   <= '0;
         b_abs_q   <= '0;
         a_neg_q   <= 1'b0;
         b_neg_q   <= 1'b0;
         acc_q     <= '0;
         fix_q     <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         funct3_q  <= funct3_d;
         a_abs_q   <= a_abs_d;
         b_abs_q   <= b_abs_d;
         a_neg_q   <= a_neg_d;
         b_neg_q   <= b_neg_d;
         acc_q     <= acc_d;
         fix_q     <= fix_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE) && !flush;
   assign result = done ? fix_q : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency, flush, ignored restart, reset.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct3    (funct3),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble the inputs after acceptance, and time the done pulse
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      start = 1'b1; funct3 = f; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      start = 1'b0; funct3 = ~f; operand_a = ~a; operand_b = ~b;
      lat = 1;
      while (!done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val({tag, " latency"}, lat, exp_lat);
      check_val({tag, " result"}, result, exp);
      check_val({tag, " busy@done"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check_val({tag, " done after"}, {31'd0, done}, 32'd0);
      check_val({tag, " busy after"}, {31'd0, busy}, 32'd0);
      check_val({tag, " result held"}, result, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  lat;
      bit  saw;

      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000;
      operand_a = 32'd0; operand_b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset busy", {31'd0, busy}, 32'd0);
      check_val("reset done", {31'd0, done}, 32'd0);
      check_val("reset result", result, 32'd0);
      @(negedge clk); rst = 1'b0;

      run_op("MUL 7*-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      run_op("MULH 7*-3",    3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
      run_op("MULHU 7*-3",   3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, 34);
      run_op("MULHSU -1*max",3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
      run_op("MULHU max*max",3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      run_op("MUL x0",       3'b000, 32'h12345678, 32'd0,        32'd0,        34);
      run_op("DIV -20/3",    3'b100, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 34);
      run_op("REM -20/3",    3'b110, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34);
      run_op("DIVU 20/3",    3'b101, 32'd20,       32'd3,        32'd6,        34);
      run_op("REMU 20/3",    3'b111, 32'd20,       32'd3,        32'd2,        34);
      run_op("DIV 5/0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("REMU 5/0",     3'b111, 32'd5,        32'd0,        32'd5,        1);
      run_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // Flush an in-flight MUL at +10; last published result was 0 (REM ovf)
      saw = 1'b0;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd4;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
         if (done) saw = 1'b1;
      end
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check_val("flush busy", {31'd0, busy}, 32'd0);
      check_val("flush done", {31'd0, done}, 32'd0);
      check_val("flush result", result, 32'd0);
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) saw = 1'b1;
      end
      check_val("flush no pulse", {31'd0, saw}, 32'd0);
      run_op("MUL after flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

      // Flush and start together in IDLE: request dropped
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_a = 32'd5; operand_b = 32'd5;
      @(posedge clk); #1; start = 1'b0; flush = 1'b0;
      check_val("flush+start busy", {31'd0, busy}, 32'd0);

      // Second start at +5 must be ignored
      @(negedge clk);
      start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      lat = 1;
      repeat (3) begin
         @(posedge clk); #1;
         lat++;
      end
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; operand_a = 32'd9; operand_b = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      lat++;
      while (!done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("restart latency", lat, 34);
      check_val("restart result", result, 32'd14);
      @(posedge clk); #1;
      check_val("restart single done", {31'd0, done}, 32'd0);
      check_val("restart busy low", {31'd0, busy}, 32'd0);

      // Reset at +20 clears everything
      @(negedge clk);
      start = 1'b1; funct3 = 3'b100; operand_a = 32'd100; operand_b = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (18) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check_val("rst busy", {31'd0, busy}, 32'd0);
      check_val("rst done", {31'd0, done}, 32'd0);
      check_val("rst result", result, 32'd0);
      @(negedge clk); rst = 1'b0;
      run_op("DIVU after rst", 3'b101, 32'd100, 32'd7, 32'd14, 34);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
